// File: rtl/cpu_defines.sv
// Encodings shared between the control unit and the EX-stage divider.
// Helpers classify a divide opcode as signed and/or remainder-producing.
package cpu_defines;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  function automatic logic div_op_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic div_op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
// Both directions use valid/ready: a beat transfers on a rising edge where valid && ready.
interface div_unit_if #(parameter int XLEN = 32);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [1:0]      div_op_i;
  logic [XLEN-1:0] operand_a_i;
  logic [XLEN-1:0] operand_b_i;
  logic            flush_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  modport master (
    output req_valid_i, div_op_i, operand_a_i, operand_b_i, flush_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, result_o, busy_o
  );

  modport slave (
    input  req_valid_i, div_op_i, operand_a_i, operand_b_i, flush_i, resp_ready_i,
    output req_ready_o, resp_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iterations.
module div_unit
  import cpu_defines::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            fix_q, fix_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [XLEN-1:0] a_q, a_d;
  logic            rsel_q, rsel_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            resp_valid_q, resp_valid_d;

  logic            accept;
  logic            op_signed;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            b_zero, is_ovf;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] quo_sh, trial;
  logic            ge;
  logic [XLEN-1:0] q_fix, r_fix, result_sel;

  assign bus.req_ready_o  = (state_q == S_IDLE) && rst_n && !bus.flush_i;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.result_o     = result_q;
  assign bus.busy_o       = (state_q != S_IDLE);
  assign dbg_state_o      = state_q;

  assign accept    = bus.req_valid_i && bus.req_ready_o;
  assign op_signed = div_op_signed(bus.div_op_i);
  assign abs_a     = (op_signed && bus.operand_a_i[XLEN-1]) ? -bus.operand_a_i : bus.operand_a_i;
  assign abs_b     = (op_signed && bus.operand_b_i[XLEN-1]) ? -bus.operand_b_i : bus.operand_b_i;
  assign b_zero    = (bus.operand_b_i == '0);
  assign is_ovf    = op_signed && (bus.operand_a_i == MIN_NEG) && (bus.operand_b_i == '1);

  // One restoring step: the shifted value is the 33-bit partial remainder. When it is
  // >= divisor the true difference is below 2^32, so a 32-bit subtract is exact.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign quo_sh = {quo_q[XLEN-2:0], 1'b0};
  assign ge     = (rem_sh >= {1'b0, div_q});
  assign trial  = rem_sh[XLEN-1:0] - div_q;

  always_comb begin
    q_fix = negq_q ? -quo_q : quo_q;
    r_fix = negr_q ? -rem_q : rem_q;
    if (zero_q) begin
      q_fix = '1;
      r_fix = a_q;
    end else if (ovf_q) begin
      q_fix = MIN_NEG;
      r_fix = '0;
    end
    result_sel = rsel_q ? r_fix : q_fix;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fix_d        = fix_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    div_d        = div_q;
    a_d          = a_q;
    rsel_d       = rsel_q;
    negq_d       = negq_q;
    negr_d       = negr_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    result_d     = result_q;
    resp_valid_d = resp_valid_q;

    if (bus.flush_i) begin
      state_d      = S_IDLE;
      fix_d        = 1'b0;
      resp_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d = S_CALC;
            cnt_d   = 5'd31;
            quo_d   = abs_a;
            rem_d   = '0;
            div_d   = abs_b;
            a_d     = bus.operand_a_i;
            rsel_d  = div_op_is_rem(bus.div_op_i);
            negq_d  = op_signed && !b_zero && (bus.operand_a_i[XLEN-1] ^ bus.operand_b_i[XLEN-1]);
            negr_d  = op_signed && bus.operand_a_i[XLEN-1];
            zero_d  = b_zero;
            ovf_d   = is_ovf;
`ifdef DIV_EARLY_OUT_EN
            fix_d   = b_zero || is_ovf;
`else
            fix_d   = 1'b0;
`endif
          end
        end
        S_CALC: begin
          // fix_q marks the exit edge that follows the last iteration
          if (fix_q) begin
            fix_d        = 1'b0;
            result_d     = result_sel;
            resp_valid_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            rem_d = ge ? trial : rem_sh[XLEN-1:0];
            quo_d = {quo_sh[XLEN-1:1], ge};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) fix_d = 1'b1;
          end
        end
        S_DONE: begin
          if (bus.resp_ready_i) begin
            resp_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
        default: begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fix_q        <= 1'b0;
      quo_q        <= '0;
      rem_q        <= '0;
      div_q        <= '0;
      a_q          <= '0;
      rsel_q       <= 1'b0;
      negq_q       <= 1'b0;
      negr_q       <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fix_q        <= fix_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      div_q        <= div_d;
      a_q          <= a_d;
      rsel_q       <= rsel_d;
      negq_q       <= negq_d;
      negr_q       <= negr_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: results, latency, handshake hold, flush and reset abort.
// Expected latencies follow DIV_EARLY_OUT_EN when it is defined for the build.
module tb_div_unit;
  import cpu_defines::*;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_unit_if #(.XLEN(32)) bus ();
  logic [1:0] dbg_state;

  div_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int t = 0;
    while (!bus.req_ready_o && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t == 100) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    bus.req_valid_i = 1'b1;
    bus.div_op_i    = op;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.operand_a_i = $urandom;
    bus.operand_b_i = $urandom;
    bus.div_op_i    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_resp(input string tag, input int exp_lat, output logic [31:0] res);
    int lat = 0;
    while (!bus.resp_valid_o && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    res = bus.result_o;
  endtask

  task automatic consume(input string tag);
    bus.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b0;
    check({tag, "_valid_drop"}, bus.resp_valid_o, 1'b0);
    check({tag, "_idle"}, bus.busy_o, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit special);
    logic [31:0] res;
    exp_q.push_back(exp);
    issue(tag, op, a, b);
    check({tag, "_busy"}, bus.busy_o, 1'b1);
    check({tag, "_ready_low"}, bus.req_ready_o, 1'b0);
    wait_resp(tag, (special && EARLY) ? 1 : 33, res);
    check(tag, res, exp_q.pop_front());
    consume(tag);
  endtask

  task automatic abort_test(input string tag, input bit use_reset);
    bit seen = 1'b0;
    issue(tag, DIV_OP_DIV, 32'd1000, 32'd3);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check({tag, "_in_calc"}, dbg_state, 2'd1);
    bus.req_valid_i = 1'b1;
    bus.div_op_i    = DIV_OP_DIVU;
    bus.operand_a_i = 32'd9;
    bus.operand_b_i = 32'd3;
    if (use_reset) rst_n = 1'b0;
    else bus.flush_i = 1'b1;
    @(posedge clk); #1;
    if (use_reset) check({tag, "_ready_in_rst"}, bus.req_ready_o, 1'b0);
    rst_n           = 1'b1;
    bus.flush_i     = 1'b0;
    bus.req_valid_i = 1'b0;
    #1;
    check({tag, "_busy"}, bus.busy_o, 1'b0);
    check({tag, "_valid"}, bus.resp_valid_o, 1'b0);
    check({tag, "_ready"}, bus.req_ready_o, 1'b1);
    if (use_reset) check({tag, "_result_clr"}, bus.result_o, 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.resp_valid_o || bus.busy_o) seen = 1'b1;
    end
    check({tag, "_quiet"}, seen, 1'b0);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] res;
    logic [31:0] held;
    bit stable;
    rst_n            = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.div_op_i     = DIV_OP_DIV;
    bus.operand_a_i  = '0;
    bus.operand_b_i  = '0;
    bus.flush_i      = 1'b0;
    bus.resp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dbg_state, 2'd0);
    check("rst_valid", bus.resp_valid_o, 1'b0);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_ready_low", bus.req_ready_o, 1'b0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", bus.req_ready_o, 1'b1);

    run_op("div_100_7",    DIV_OP_DIV,  32'd100,      32'd7,        32'd14,       1'b0);
    run_op("rem_m7_2",     DIV_OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    run_op("div_m7_2",     DIV_OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    run_op("div_7_m2",     DIV_OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
    run_op("rem_7_m2",     DIV_OP_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        1'b0);
    run_op("divu_max_1",   DIV_OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0);
    run_op("remu_max_16",  DIV_OP_REMU, 32'hFFFFFFFF, 32'h10,       32'hF,        1'b0);
    run_op("divu_min_max", DIV_OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0);
    run_op("div_5_0",      DIV_OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
    run_op("rem_5_0",      DIV_OP_REM,  32'd5,        32'd0,        32'd5,        1'b1);
    run_op("rem_m5_0",     DIV_OP_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1);
    run_op("divu_5_0",     DIV_OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
    run_op("remu_7_0",     DIV_OP_REMU, 32'd7,        32'd0,        32'd7,        1'b1);
    run_op("div_ovf",      DIV_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op("rem_ovf",      DIV_OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1);

    // response held while the consumer stalls
    issue("hold", DIV_OP_DIVU, 32'd1000, 32'd10);
    wait_resp("hold", 33, res);
    check("hold_result", res, 32'd100);
    held   = res;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!bus.resp_valid_o || bus.result_o !== held) stable = 1'b0;
    end
    check("hold_stable", stable, 1'b1);
    check("hold_state", dbg_state, 2'd2);
    bus.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b0;
    check("release_valid", bus.resp_valid_o, 1'b0);
    check("release_ready", bus.req_ready_o, 1'b1);
    run_op("b2b_rem", DIV_OP_REM, 32'd100, 32'd7, 32'd2, 1'b0);

    run_op("pre_abort", DIV_OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0);
    abort_test("flush", 1'b0);
    check("flush_keeps_result", bus.result_o, 32'd14);
    abort_test("reset", 1'b1);
    run_op("after_abort", DIV_OP_DIVU, 32'd81, 32'd9, 32'd9, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
